// File: rtl/bcd_scan_counter_pkg.sv
// Constants and helpers shared by the BCD scan counter and its decade cells.
package bcd_scan_counter_pkg;

    localparam int              BCD_W      = 4;
    localparam logic [BCD_W-1:0] BCD_MAX   = 4'd9;
    localparam int              MAX_DIGITS = 8;

    // Active-low select with only bit idx low; bits at or above n stay high.
    function automatic logic [MAX_DIGITS-1:0] onehot_n(input int idx, input int n);
        logic [MAX_DIGITS-1:0] sel;
        sel = '1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i == idx && i < n) begin
                sel[i] = 1'b0;
            end
        end
        return sel;
    endfunction

    function automatic logic [BCD_W-1:0] digit_slice(input logic [BCD_W*MAX_DIGITS-1:0] vec,
                                                     input int idx);
        return vec[idx*BCD_W +: BCD_W];
    endfunction

endpackage

// File: rtl/bcd_scan_counter_digit.sv
// Single decade (0..9) counter cell; cells chain through carry_out into inc.
module bcd_digit
    import bcd_scan_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic [BCD_W-1:0] q_next,
    output logic             carry_out
);

    logic [BCD_W-1:0] q_q, q_d;
    logic             at_max;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        at_max    = (q_q >= BCD_MAX);
        q_d       = q_q;
        carry_out = inc && at_max;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = at_max ? '0 : q_q + BCD_W'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign q_next = q_d;

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD event counter with prescaled increment and a time-multiplexed
// digit scanner driving a common-anode display through seven_segment.
module bcd_scan_counter
    import bcd_scan_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int COUNT_DIV  = 50000000,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clr,
    output logic [BCD_W-1:0]            bcd,
    output logic [NUM_DIGITS-1:0]       digit_sel,
    output logic [BCD_W*NUM_DIGITS-1:0] count_bcd,
    output logic                        rollover
);

    localparam int CNT_W  = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] SEL_RESET = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [SCAN_W-1:0]             scan_q, scan_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [BCD_W-1:0]              bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]         sel_q, sel_d;
    logic                          rollover_q, rollover_d;
    logic                          tick;
    logic [NUM_DIGITS:0]           carry;
    logic [BCD_W*NUM_DIGITS-1:0]   count_vec, count_next_vec;
    logic [BCD_W*MAX_DIGITS-1:0]   next_padded;
    logic [MAX_DIGITS-1:0]         sel_full;

    assign carry[0] = tick;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .inc       (carry[g]),
            .q         (count_vec[g*BCD_W +: BCD_W]),
            .q_next    (count_next_vec[g*BCD_W +: BCD_W]),
            .carry_out (carry[g+1])
        );
    end

    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_W'(COUNT_DIV - 1)) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Scanning free-runs; clr and en never touch it.
        scan_d = scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        // Select from the post-increment digits so bcd never lags count_bcd.
        next_padded                          = '0;
        next_padded[BCD_W*NUM_DIGITS-1:0]    = count_next_vec;
        bcd_d                                = digit_slice(next_padded, int'(idx_d));
        sel_full                             = onehot_n(int'(idx_d), NUM_DIGITS);
        sel_d                                = sel_full[NUM_DIGITS-1:0];
        rollover_d                           = carry[NUM_DIGITS];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            scan_q     <= '0;
            idx_q      <= '0;
            bcd_q      <= '0;
            sel_q      <= SEL_RESET;
            rollover_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            bcd_q      <= bcd_d;
            sel_q      <= sel_d;
            rollover_q <= rollover_d;
        end
    end

    assign bcd       = bcd_q;
    assign digit_sel = sel_q;
    assign count_bcd = count_vec;
    assign rollover  = rollover_q;

endmodule
